// File: rtl/sample_pkg.sv
// Shared definitions for the linear-interpolating upsampler.
package sample_pkg;

   localparam int DEF_BIT_WIDTH = 24;
   localparam int DEF_MAX_LOG2  = 4;

   typedef enum logic {
      WAIT,
      EMIT
   } state_t;

   // Limits a requested log2 upsampling ratio to the largest one the datapath supports.
   function automatic int clamp_log2(input logic [2:0] sel, input int max_log2);
      int s;
      s = int'(sel);
      return (s > max_log2) ? max_log2 : s;
   endfunction

endpackage

// File: rtl/interp_phase_calc.sv
// Combinational phase interpolator: q = prev + floor((cur - prev) * (k + 1) / 2^l).
// Every intermediate is wide enough to hold the full product, so nothing overflows.
// The result always lies between prev and cur, so truncating it back to BIT_WIDTH
// loses nothing.
module interp_phase_calc #(
   parameter int BIT_WIDTH = 24,
   parameter int MAX_LOG2  = 4,
   parameter int L_WIDTH   = 3
) (
   input  logic signed [BIT_WIDTH-1:0] prev,
   input  logic signed [BIT_WIDTH-1:0] cur,
   input  logic        [MAX_LOG2-1:0]  k,
   input  logic        [L_WIDTH-1:0]   l,
   output logic signed [BIT_WIDTH-1:0] q
);

   localparam int DW = BIT_WIDTH + 1;
   localparam int KW = MAX_LOG2 + 2;
   localparam int PW = DW + KW;

   logic signed [DW-1:0] diff;
   logic signed [KW-1:0] step;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic signed [PW-1:0] prev_ext;

   // Form the scaled difference, apply the floor shift, and add it back onto prev.
   always_comb begin
      diff     = {cur[BIT_WIDTH-1], cur} - {prev[BIT_WIDTH-1], prev};
      step     = {2'b00, k} + KW'(1);
      prod     = PW'(diff) * PW'(step);
      shifted  = prod >>> l;
      prev_ext = {{(PW - BIT_WIDTH){prev[BIT_WIDTH-1]}}, prev};
      q        = BIT_WIDTH'(prev_ext + shifted);
   end

endmodule

// File: rtl/sample_interp.sv
// Linear-interpolating upsampler. Each accepted input sample produces 2^L output
// samples that ramp from the previous input up to the new one. Both the input and
// output sides use valid/ready handshakes.
module sample_interp
   import sample_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int MAX_LOG2  = DEF_MAX_LOG2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic        [2:0]           ratio_sel,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [BIT_WIDTH-1:0] d,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [BIT_WIDTH-1:0] q
);

   localparam int L_WIDTH = $clog2(MAX_LOG2 + 1);

   state_t                       state;
   logic signed [BIT_WIDTH-1:0]  prev;
   logic signed [BIT_WIDTH-1:0]  cur;
   logic        [MAX_LOG2-1:0]   k;
   logic        [L_WIDTH-1:0]    l_reg;
   logic        [L_WIDTH-1:0]    l_next;
   logic        [MAX_LOG2-1:0]   last_k;
   logic                         at_last;
   logic                         accept_in;

   // The ratio is only clamped here; it is latched into l_reg when a sample is accepted.
   // The phase counter runs from 0 up to 2^L - 1.
   always_comb begin
      l_next    = L_WIDTH'(clamp_log2(ratio_sel, MAX_LOG2));
      last_k    = MAX_LOG2'((1 << l_reg) - 1);
      at_last   = (k == last_k);
      in_ready  = (state == WAIT) || ((state == EMIT) && at_last && out_ready);
      out_valid = (state == EMIT);
      accept_in = in_valid && in_ready;
   end

   // Control FSM. On reset the burst is abandoned. An accepted input shifts the
   // sample pair and restarts the ramp. A consumed output advances the phase, or
   // goes back to WAIT when the last phase is consumed with no new input waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev  <= '0;
         cur   <= '0;
         k     <= '0;
         l_reg <= '0;
         state <= WAIT;
      end else if (accept_in) begin
         prev  <= cur;
         cur   <= d;
         k     <= '0;
         l_reg <= l_next;
         state <= EMIT;
      end else if ((state == EMIT) && out_ready) begin
         if (!at_last) begin
            k <= k + 1'b1;
         end else begin
            state <= WAIT;
         end
      end
   end

   interp_phase_calc #(
      .BIT_WIDTH(BIT_WIDTH),
      .MAX_LOG2 (MAX_LOG2),
      .L_WIDTH  (L_WIDTH)
   ) u_phase_calc (
      .prev(prev),
      .cur (cur),
      .k   (k),
      .l   (l_reg),
      .q   (q)
   );

endmodule

// File: tb/tb_sample_interp.sv
// Directed self-checking bench for sample_interp with hand-computed expected values.
module tb_sample_interp;

   localparam int BW = 24;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [2:0]           ratio_sel;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [BW-1:0] d;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [BW-1:0] q;

   int assertCount = 0;
   int failCount   = 0;

   sample_interp #(
      .BIT_WIDTH(BW),
      .MAX_LOG2 (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ratio_sel(ratio_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .d        (d),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q        (q)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Advances one cycle; inputs are driven and outputs are sampled 1 ns after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Counts a comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drives every DUT input except reset.
   task automatic applyStimulus(input logic valid, input longint data, input int ratio, input logic ready);
      in_valid  = valid;
      d         = BW'(data);
      ratio_sel = 3'(ratio);
      out_ready = ready;
   endtask

   // Holds reset for two edges, then checks the idle state.
   task automatic resetDut;
      reset = 1'b1;
      applyStimulus(1'b0, 0, 0, 1'b1);
      tick;
      tick;
      reset = 1'b0;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset q", q, 0);
   endtask

   // Presents one sample for a single cycle, which must be accepted.
   task automatic sendSample(input longint data, input int ratio);
      applyStimulus(1'b1, data, ratio, 1'b1);
      checkOutput("in_ready before send", in_ready, 1);
      tick;
      applyStimulus(1'b0, 0, ratio, 1'b1);
   endtask

   // Checks the current output phase, then lets the consumer take it.
   task automatic expectOut(input string tag, input longint expected);
      checkOutput({tag, " valid"}, out_valid, 1);
      checkOutput({tag, " q"}, q, expected);
      tick;
   endtask

   longint b2bVec [6] = '{5, -7, 1000, -8388608, 8388607, 0};
   longint lastQ;
   longint modelQ;
   longint modelDiff;

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 0, 0, 1'b1);
      resetDut();

      // 1: ramp from 0 up to 400 in four steps.
      sendSample(400, 2);
      expectOut("t1 k0", 100);
      expectOut("t1 k1", 200);
      expectOut("t1 k2", 300);
      expectOut("t1 k3", 400);
      checkOutput("t1 idle out_valid", out_valid, 0);
      checkOutput("t1 idle in_ready", in_ready, 1);

      // 2: ramp back down from 400 to -400.
      sendSample(-400, 2);
      expectOut("t2 k0", 200);
      expectOut("t2 k1", 0);
      expectOut("t2 k2", -200);
      expectOut("t2 k3", -400);
      checkOutput("t2 idle out_valid", out_valid, 0);

      // 3: floor rounding of a negative half step.
      resetDut();
      sendSample(-3, 1);
      expectOut("t3 k0", -2);
      expectOut("t3 k1", -3);
      checkOutput("t3 idle out_valid", out_valid, 0);

      // 4: output backpressure holds phase 1 for five cycles.
      resetDut();
      sendSample(400, 2);
      expectOut("t4 k0", 100);
      applyStimulus(1'b0, 0, 2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("t4 stall%0d valid", i), out_valid, 1);
         checkOutput($sformatf("t4 stall%0d q", i), q, 200);
         checkOutput($sformatf("t4 stall%0d in_ready", i), in_ready, 0);
         tick;
      end
      out_ready = 1'b1;
      expectOut("t4 k1", 200);
      expectOut("t4 k2", 300);
      checkOutput("t4 k3 in_ready", in_ready, 1);
      expectOut("t4 k3", 400);
      checkOutput("t4 idle out_valid", out_valid, 0);

      // 5: ratio clamp to 16 phases across full-scale extremes.
      sendSample(8388607, 0);
      expectOut("t5 pre", 8388607);
      sendSample(-8388608, 7);
      lastQ = 8388607;
      modelDiff = -16777215;
      for (int i = 0; i < 16; i++) begin
         modelQ = 8388607 + ((modelDiff * longint'(i + 1)) >>> 4);
         checkOutput($sformatf("t5 monotone%0d", i), longint'(q <= lastQ), 1);
         lastQ = q;
         expectOut($sformatf("t5 k%0d", i), modelQ);
      end
      checkOutput("t5 last", lastQ, -8388608);
      checkOutput("t5 idle out_valid", out_valid, 0);

      // 6: pass-through at one sample per cycle.
      applyStimulus(1'b1, b2bVec[0], 0, 1'b1);
      tick;
      for (int i = 1; i < 6; i++) begin
         checkOutput($sformatf("t6 in_ready%0d", i), in_ready, 1);
         checkOutput($sformatf("t6 valid%0d", i), out_valid, 1);
         checkOutput($sformatf("t6 q%0d", i), q, b2bVec[i-1]);
         d = BW'(b2bVec[i]);
         tick;
      end
      in_valid = 1'b0;
      checkOutput("t6 final q", q, b2bVec[5]);
      tick;
      checkOutput("t6 idle out_valid", out_valid, 0);

      // 7: reset at phase 2 abandons the burst.
      sendSample(400, 2);
      expectOut("t7 k0", 100);
      expectOut("t7 k1", 200);
      checkOutput("t7 k2 q", q, 300);
      reset = 1'b1;
      tick;
      checkOutput("t7 reset out_valid", out_valid, 0);
      checkOutput("t7 reset q", q, 0);
      checkOutput("t7 reset in_ready", in_ready, 1);
      reset = 1'b0;
      tick;
      checkOutput("t7 no partial", out_valid, 0);
      sendSample(8, 1);
      expectOut("t7 ramp k0", 4);
      expectOut("t7 ramp k1", 8);
      checkOutput("t7 idle out_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
